// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op codes, arbiter FSM states and flag bit positions
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110
  } alu_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_e;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;
  function automatic logic is_illegal(input logic [2:0] c);
    return c == 3'b001 || c == 3'b111;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: 64-bit combinational ALU; a_i/b_i operands, cntrl_i op code, result_o result, flags_o {N,Z,V,C}
module alu
  import alu_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [2:0]  cntrl_i,
  output logic [63:0] result_o,
  output logic [3:0]  flags_o
);
  logic        sub, arith;
  logic [63:0] bx;
  logic [64:0] sum;
  always_comb begin
    sub   = cntrl_i == ALU_SUBTRACT;
    arith = sub || cntrl_i == ALU_ADD;
    bx    = sub ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, bx} + {64'd0, sub};
    result_o = cntrl_i == ALU_PASS_B ? b_i :
               arith                 ? sum[63:0] :
               cntrl_i == ALU_AND    ? a_i & b_i :
               cntrl_i == ALU_OR     ? a_i | b_i :
               cntrl_i == ALU_XOR    ? a_i ^ b_i : 64'd0;
    flags_o = '0;
    flags_o[FLAG_N] = result_o[63];
    flags_o[FLAG_Z] = result_o == 64'd0;
    // signed overflow: operands (after inversion for subtract) agree in sign, result does not
    flags_o[FLAG_V] = arith && (a_i[63] == bx[63]) && (sum[63] != a_i[63]);
    // for subtract this is the no-borrow carry of a + ~b + 1
    flags_o[FLAG_C] = arith && sum[64];
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one registered ALU via IDLE->EXEC->RESP handshakes
// clk/reset_n: clock, async active-low reset; req_*: operation requests with per-requester ready;
// rsp_*: one-hot response valid/ready with registered result, flags {N,Z,V,C} and illegal-op error.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit CHECK_CNTRL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [63:0] req0_A,
  input  logic [63:0] req0_B,
  input  logic [63:0] req1_A,
  input  logic [63:0] req1_B,
  input  logic [2:0]  req0_cntrl,
  input  logic [2:0]  req1_cntrl,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [63:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err
);
  state_e      state_q, state_d;
  logic        rr_q, owner_q, gnt, hs, rsp_done, err, err_q;
  logic [63:0] a_q, b_q, res_q, alu_res;
  logic [2:0]  cntrl_q;
  logic [3:0]  flags_q, alu_flags;
  alu u_alu (
    .a_i     (a_q),
    .b_i     (b_q),
    .cntrl_i (cntrl_q),
    .result_o(alu_res),
    .flags_o (alu_flags)
  );
  always_comb begin
    gnt       = &req_valid ? rr_q : req_valid[1];
    // reset_n gates ready so nothing is offered while reset is held
    hs        = reset_n && state_q == ST_IDLE && |req_valid;
    req_ready = hs ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid = state_q == ST_RESP ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_done  = state_q == ST_RESP && rsp_ready[owner_q];
    err       = CHECK_CNTRL && is_illegal(cntrl_q);
    state_d   = state_q == ST_EXEC ? ST_RESP :
                hs                 ? ST_EXEC :
                rsp_done           ? ST_IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      cntrl_q <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        owner_q <= gnt;
        a_q     <= gnt ? req1_A : req0_A;
        b_q     <= gnt ? req1_B : req0_B;
        cntrl_q <= gnt ? req1_cntrl : req0_cntrl;
      end
      if (state_q == ST_EXEC) begin
        res_q   <= err ? 64'd0 : alu_res;
        flags_q <= err ? 4'd0 : alu_flags;
        err_q   <= err;
      end
      if (rsp_done) rr_q <= ~owner_q;
    end
  end
  assign rsp_result = res_q;
  assign rsp_flags  = flags_q;
  assign rsp_err    = err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench with directed scenarios and randomized traffic
module tb_alu_arbiter;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic [1:0]  req_valid = 2'b00, rsp_ready = 2'b00, req_ready, rsp_valid;
  logic [63:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0, rsp_result;
  logic [2:0]  req0_cntrl = '0, req1_cntrl = '0;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  always #5 clk = ~clk;
  alu_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_A(req0_A), .req0_B(req0_B), .req1_A(req1_A), .req1_B(req1_B),
    .req0_cntrl(req0_cntrl), .req1_cntrl(req1_cntrl), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );
  typedef struct {logic [63:0] a, b; logic [2:0] c;} op_t;
  typedef struct {logic owner; logic [63:0] res; logic [3:0] fl; logic err;} rsp_t;
  op_t  pend0[$], pend1[$];
  rsp_t sb[$], log_q[$];
  int   grants[$];
  int   checks = 0, errors = 0, cyc = 0, acc_cyc = 0, rdy_mode = 0;
  bit   rr = 1'b0, rand_drop = 1'b0;
  logic [1:0] taken = 2'b00, exp_v;
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h (t=%0t)", n, got, exp, $time);
    end
  endtask
  function automatic rsp_t model(input logic owner, input op_t o);
    rsp_t e;
    logic [63:0] r;
    logic [64:0] s;
    logic v, c;
    e.owner = owner;
    e.err = 1'b0;
    v = 1'b0;
    c = 1'b0;
    r = '0;
    case (o.c)
      3'b000: r = o.b;
      3'b010: begin
        s = {1'b0, o.a} + {1'b0, o.b};
        r = s[63:0];
        c = s[64];
        v = (o.a[63] == o.b[63]) && (r[63] != o.a[63]);
      end
      3'b011: begin
        r = o.a - o.b;
        c = o.a >= o.b;
        v = (o.a[63] != o.b[63]) && (r[63] != o.a[63]);
      end
      3'b100: r = o.a & o.b;
      3'b101: r = o.a | o.b;
      3'b110: r = o.a ^ o.b;
      default: e.err = 1'b1;
    endcase
    e.res = r;
    e.fl = e.err ? 4'b0000 : {r[63], r == 64'd0, v, c};
    return e;
  endfunction
  // monitor + reference model
  always @(negedge clk) begin
    op_t o;
    cyc++;
    if (!reset_n) begin
      sb.delete();
      rr = 1'b0;
      taken = 2'b00;
      chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
      chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
      chk("rst_rsp_result", rsp_result, 64'd0);
      chk("rst_flags_err", {59'd0, rsp_flags, rsp_err}, 64'd0);
    end else begin
      exp_v = sb.size() != 0 ? 2'b00 : req_valid == 2'b11 ? (rr ? 2'b10 : 2'b01) : req_valid;
      chk("req_ready", {62'd0, req_ready}, {62'd0, exp_v});
      taken = req_valid & req_ready;
      if (taken != 2'b00) begin
        o.a = taken[1] ? req1_A : req0_A;
        o.b = taken[1] ? req1_B : req0_B;
        o.c = taken[1] ? req1_cntrl : req0_cntrl;
        sb.push_back(model(taken[1], o));
        grants.push_back(int'(taken[1]));
        acc_cyc = cyc;
      end
      if (sb.size() == 0) chk("rsp_valid_idle", {62'd0, rsp_valid}, 64'd0);
      else begin
        exp_v = (cyc - acc_cyc >= 2) ? (sb[0].owner ? 2'b10 : 2'b01) : 2'b00;
        chk("rsp_valid", {62'd0, rsp_valid}, {62'd0, exp_v});
        if (exp_v != 2'b00) begin
          chk("rsp_result", rsp_result, sb[0].res);
          chk("rsp_flags_err", {59'd0, rsp_flags, rsp_err}, {59'd0, sb[0].fl, sb[0].err});
          if (rsp_ready[sb[0].owner]) begin
            log_q.push_back('{owner: sb[0].owner, res: rsp_result, fl: rsp_flags, err: rsp_err});
            rr = ~sb[0].owner;
            void'(sb.pop_front());
          end
        end
      end
    end
  end
  task automatic drive_one(input int i);
    op_t o;
    if (taken[i]) begin
      req_valid[i] = 1'b0;
      if (i == 0) pend0.delete(0); else pend1.delete(0);
    end
    if (req_valid[i] && rand_drop && $urandom_range(4) == 0) req_valid[i] = 1'b0;
    else if (!req_valid[i] && (i == 0 ? pend0.size() : pend1.size()) > 0 &&
             !(rand_drop && $urandom_range(3) == 0)) begin
      o = i == 0 ? pend0[0] : pend1[0];
      if (i == 0) {req0_A, req0_B, req0_cntrl} = {o.a, o.b, o.c};
      else {req1_A, req1_B, req1_cntrl} = {o.a, o.b, o.c};
      req_valid[i] = 1'b1;
    end
  endtask
  always @(posedge clk) begin
    #1;
    drive_one(0);
    drive_one(1);
    rsp_ready = rdy_mode == 0 ? 2'b11 : rdy_mode == 1 ? 2'($urandom) : 2'b00;
  end
  task automatic wait_idle(input int limit);
    bit done = 1'b0;
    for (int k = 0; k < limit && !done; k++) begin
      @(negedge clk);
      done = pend0.size() == 0 && pend1.size() == 0 && req_valid == 2'b00 && sb.size() == 0;
    end
    chk("drain_timeout", {63'd0, done}, 64'd1);
  endtask
  function automatic logic [63:0] rand_val();
    case ($urandom_range(5))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction
  initial begin
    bit got_hs;
    // both requesters valid straight out of reset
    pend0.push_back('{a: 64'hDEADBEEFDECAFBAD, b: 64'hDEADBEEFDECAFBAD, c: 3'b011});
    pend1.push_back('{a: 64'h1234_5678_9ABC_DEF0, b: 64'h0F0F_0F0F_0F0F_0F0F, c: 3'b110});
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    wait_idle(50);
    chk("first_two_grants", {grants[0][31:0], grants[1][31:0]}, {32'd0, 32'd1});
    chk("sub_eq_result", log_q[0].res, 64'd0);
    chk("sub_eq_flags", {60'd0, log_q[0].fl}, 64'h5);
    chk("xor_result", log_q[1].res, 64'h1D3B_5977_95B3_D1FF);
    // signed overflow on add
    log_q.delete();
    pend0.push_back('{a: 64'h7FFF_FFFF_FFFF_FFFF, b: 64'd1, c: 3'b010});
    wait_idle(50);
    chk("add_ovf_owner", {63'd0, log_q[0].owner}, 64'd0);
    chk("add_ovf_result", log_q[0].res, 64'h8000_0000_0000_0000);
    chk("add_ovf_flags", {60'd0, log_q[0].fl}, 64'hA);
    // illegal op then AND on requester 1
    log_q.delete();
    pend1.push_back('{a: 64'h5555, b: 64'h3333, c: 3'b111});
    pend1.push_back('{a: 64'hF0F0_F0F0_F0F0_F0F0, b: 64'hFF00_FF00_FF00_FF00, c: 3'b100});
    wait_idle(50);
    chk("illegal_err", {59'd0, log_q[0].err, log_q[0].fl}, {59'd0, 1'b1, 4'd0});
    chk("illegal_result", log_q[0].res, 64'd0);
    chk("and_result", log_q[1].res, 64'hF000_F000_F000_F000);
    chk("and_err", {63'd0, log_q[1].err}, 64'd0);
    // six back-to-back ops with both always requesting
    grants.delete();
    for (int i = 0; i < 3; i++) begin
      pend0.push_back('{a: rand_val(), b: rand_val(), c: 3'b010});
      pend1.push_back('{a: rand_val(), b: rand_val(), c: 3'b101});
    end
    wait_idle(100);
    chk("six_grants", grants.size(), 6);
    for (int i = 1; i < 6; i++) chk("alternate", 64'(grants[i] ^ grants[i-1]), 64'd1);
    // stalled response: nothing else may be granted
    grants.delete();
    rdy_mode = 2;
    pend0.push_back('{a: 64'd5, b: 64'd9, c: 3'b011});
    pend1.push_back('{a: 64'd1, b: 64'd2, c: 3'b000});
    repeat (8) @(negedge clk);
    chk("stall_one_grant", grants.size(), 1);
    rdy_mode = 0;
    wait_idle(50);
    // reset in EXEC aborts the operation
    log_q.delete();
    pend0.push_back('{a: 64'd3, b: 64'd4, c: 3'b010});
    got_hs = 1'b0;
    for (int k = 0; k < 20 && !got_hs; k++) begin
      @(negedge clk);
      got_hs = taken != 2'b00;
    end
    chk("exec_hs_seen", {63'd0, got_hs}, 64'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("abort_outs", {rsp_result[59:0], rsp_flags}, 64'd0);
    chk("abort_err_ready", {62'd0, rsp_err, |req_ready}, 64'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_rsp", log_q.size(), 0);
    // randomized traffic with backpressure and withdrawn requests
    rdy_mode = 1;
    rand_drop = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op_t o;
      o.a = rand_val();
      o.b = $urandom_range(3) == 0 ? o.a : rand_val();
      o.c = 3'($urandom);
      if ($urandom_range(1) == 0) pend0.push_back(o); else pend1.push_back(o);
    end
    wait_idle(3000);
    rand_drop = 1'b0;
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
